product_divider_4bit: RTL and testbench
=======================================

PRODUCT_DIVIDER_4BIT -- requirements
Module: product_divider_4bit

Interface
REQ-001: Ports SHALL be exactly as listed below, in this order.
REQ-002: clk  input  1  single clock; all state changes on the rising edge.
REQ-003: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004: start  input  1  request to begin a division; sampled only in IDLE.
REQ-005: p  input  8  dividend, an unsigned product of two 4-bit operands.
REQ-006: b  input  4  unsigned divisor.
REQ-007: q  output  4  unsigned quotient, registered.
REQ-008: r  output  4  unsigned remainder, registered.
REQ-009: busy  output  1  high while an accepted division is iterating.
REQ-010: done  output  1  one-cycle pulse marking valid q, r and flags.
REQ-011: dz  output  1  divide-by-zero flag, valid while done=1 and held until the next accepted start.
REQ-012: ovf  output  1  quotient-overflow flag, valid while done=1 and held until the next accepted start.

Function
REQ-013: FSM states SHALL be IDLE, RUN and DONE; busy=1 only in RUN; done=1 only in DONE.
REQ-014: IDLE with start=1 at edge E0 SHALL capture p and b into internal registers and clear dz and ovf.
REQ-015: At E0, b=0 SHALL set dz=1, q=4'hF, r=4'h0, and go to DONE.
REQ-016: At E0, b!=0 with p[7:4]>=b SHALL set ovf=1, q=4'hF, r=4'h0, and go to DONE.
REQ-017: Otherwise at E0: rem[4:0]={0,p[7:4]}, dl[3:0]=p[3:0], iteration count=0, and go to RUN.
REQ-018: Each RUN edge SHALL compute t={rem[3:0],dl[3]}; if t>=b then rem=t-b and qbit=1, else rem=t and qbit=0; then dl={dl[2:0],qbit} and count increments.
REQ-019: The 4th RUN edge (E4) SHALL load q=dl_next and r=rem_next[3:0], and go to DONE.
REQ-020: Normal latency: busy=1 during the cycles after E0 through E3; done=1 during the cycle after E4.
REQ-021: Error latency: done=1 during the cycle after E0; busy stays 0.
REQ-022: DONE SHALL return to IDLE on the next edge unconditionally; start seen in DONE or RUN SHALL be ignored.
REQ-023: q, r, dz and ovf SHALL hold their values from DONE until the next accepted start.
REQ-024: Changes on p and b after E0 SHALL NOT affect the result in progress.
REQ-025: In a normal result, q*b+r SHALL equal p and r<b.

Reset
REQ-026: rst=1 at any edge SHALL force IDLE and set q=0, r=0, busy=0, done=0, dz=0, ovf=0; rst has priority over start.
REQ-027: rst asserted mid-RUN SHALL abort the division with no done pulse; the next start after rst deasserts proceeds normally.

Verification
REQ-028: p=0x2A, b=5, start pulse -> busy for 4 cycles, then done=1 with q=8, r=2, dz=0, ovf=0.
REQ-029: p=0xE1, b=15 -> q=15, r=0, no flags; and p=0x00, b=1 -> q=0, r=0.
REQ-030: p=0x12, b=0 -> done=1 the cycle after start with dz=1, q=4'hF, r=0, busy never high.
REQ-031: p=0x50, b=5 -> done=1 the cycle after start with ovf=1, q=4'hF, r=0.
REQ-032: start p=0x2A, b=5, then start p=0x09, b=3 raised during RUN -> the second start is ignored; result is q=8, r=2.
REQ-033: rst pulsed at the 2nd RUN cycle -> all outputs 0 the next cycle with no done pulse; a new start p=0x31, b=7 -> q=7, r=0.

Source files
------------

// File: rtl/product_divider_4bit.sv
// Sequential restoring divider for an 8-bit product by a 4-bit divisor.
// Four RUN cycles yield a 4-bit quotient/remainder; errors finish in one.
module product_divider_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] p,
    input  logic [3:0] b,
    output logic [3:0] q,
    output logic [3:0] r,
    output logic       busy,
    output logic       done,
    output logic       dz,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0] dvs;
    logic [3:0] rem;
    logic [3:0] dl;
    logic [1:0] cnt;

    logic       err_zero;
    logic       err_ovf;
    logic       last;
    logic [4:0] t;
    logic       qbit;
    logic [3:0] diff;
    logic [3:0] rem_nxt;
    logic [3:0] dl_nxt;

    assign err_zero = (b == 4'd0);
    assign err_ovf  = !err_zero && (p[7:4] >= b);

    // The partial remainder is always below the divisor, so 4 bits hold it;
    // the true difference also fits in 4 bits, so modular subtraction is exact.
    assign t       = {rem, dl[3]};
    assign qbit    = (t >= {1'b0, dvs});
    assign diff    = t[3:0] - dvs;
    assign rem_nxt = qbit ? diff : t[3:0];
    assign dl_nxt  = {dl[2:0], qbit};
    assign last    = (cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (err_zero || err_ovf) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= 4'd0;
            r   <= 4'd0;
            dz  <= 1'b0;
            ovf <= 1'b0;
            dvs <= 4'd0;
            rem <= 4'd0;
            dl  <= 4'd0;
            cnt <= 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvs <= b;
                        dz  <= 1'b0;
                        ovf <= 1'b0;
                        unique case (1'b1)
                            err_zero: begin
                                dz <= 1'b1;
                                q  <= 4'hF;
                                r  <= 4'h0;
                            end
                            err_ovf: begin
                                ovf <= 1'b1;
                                q   <= 4'hF;
                                r   <= 4'h0;
                            end
                            default: begin
                                rem <= p[7:4];
                                dl  <= p[3:0];
                                cnt <= 2'd0;
                            end
                        endcase
                    end
                end
                RUN: begin
                    rem <= rem_nxt;
                    dl  <= dl_nxt;
                    cnt <= cnt + 2'd1;
                    if (last) begin
                        q <= dl_nxt;
                        r <= rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_product_divider_4bit.sv
// Scoreboard bench for product_divider_4bit: random and directed divisions
// checked against an arithmetic reference model.
module tb_product_divider_4bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] p = 8'd0;
    logic [3:0] b = 4'd0;
    logic [3:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       dz;
    logic       ovf;

    product_divider_4bit dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .p    (p),
        .b    (b),
        .q    (q),
        .r    (r),
        .busy (busy),
        .done (done),
        .dz   (dz),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int busy_seen = 0;

    typedef struct {
        logic [7:0] p;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        logic       ovf;
        int         lat;
        int         e0;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] pv, input logic [3:0] bv);
        exp_t e;
        int pi = int'(pv);
        int bi = int'(bv);
        e.p = pv;
        e.b = bv;
        e.dz = 1'b0;
        e.ovf = 1'b0;
        e.e0 = 0;
        if (bi == 0) begin
            e.dz = 1'b1;
            e.q = 4'hF;
            e.r = 4'h0;
            e.lat = 0;
        end else if (pi / bi > 15) begin
            e.ovf = 1'b1;
            e.q = 4'hF;
            e.r = 4'h0;
            e.lat = 0;
        end else begin
            e.q = 4'(pi / bi);
            e.r = 4'(pi % bi);
            e.lat = 4;
        end
        return e;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            busy_seen = 0;
        end else begin
            if (busy) busy_seen++;
            if (done) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: got done=1 required no pending op");
                end else begin
                    e = sb.pop_front();
                    chk("q", q, e.q);
                    chk("r", r, e.r);
                    chk("dz", dz, e.dz);
                    chk("ovf", ovf, e.ovf);
                    chk("latency", cyc - e.e0, e.lat);
                    chk("busy_cycles", busy_seen, e.lat);
                    if (!e.dz && !e.ovf) begin
                        chk("recompose", int'(q) * int'(e.b) + int'(r), int'(e.p));
                        chk("r_lt_b", r < e.b, 1);
                    end
                end
                busy_seen = 0;
            end
        end
    end

    task automatic issue(input logic [7:0] pv, input logic [3:0] bv,
                         input bit push);
        exp_t e;
        @(negedge clk);
        p = pv;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        p = 8'($urandom);
        b = 4'($urandom);
        if (push) begin
            e = model(pv, bv);
            e.e0 = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        bit got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL done_timeout: got no done required done within 10 cycles");
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_q"}, q, 0);
        chk({tag, "_r"}, r, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_dz"}, dz, 0);
        chk({tag, "_ovf"}, ovf, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pv;
        logic [3:0] bv;

        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        issue(8'h2A, 4'd5, 1);
        wait_done();
        repeat (3) @(negedge clk);
        chk("hold_q", q, 8);
        chk("hold_r", r, 2);

        issue(8'hE1, 4'd15, 1);
        wait_done();
        issue(8'h00, 4'd1, 1);
        wait_done();
        issue(8'h12, 4'd0, 1);
        wait_done();
        issue(8'h50, 4'd5, 1);
        wait_done();

        // Second start raised mid-RUN with new operands must be ignored.
        issue(8'h2A, 4'd5, 1);
        @(negedge clk);
        @(negedge clk);
        p = 8'h09;
        b = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("ignored_q", q, 8);
        chk("ignored_r", r, 2);

        // Reset in the second RUN cycle aborts with no done pulse.
        issue(8'h2A, 4'd5, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("abort");
        #2;
        rst = 1'b0;
        issue(8'h31, 4'd7, 1);
        wait_done();
        chk("post_abort_q", q, 7);
        chk("post_abort_r", r, 0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                pv = 8'($urandom_range(0, 15) * $urandom_range(0, 15));
            end else begin
                pv = 8'($urandom_range(0, 255));
            end
            bv = 4'($urandom_range(0, 15));
            issue(pv, bv, 1);
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
